// File: rtl/kb_pkg.sv
// Shared defaults and key-index helper for the keyboard matrix scanner.
package kb_pkg;
    localparam int KB_ROWS       = 8;
    localparam int KB_COLS       = 5;
    localparam int KB_DW         = 8;
    localparam int KB_TAPE_BIT   = 7;
    localparam int KB_TICK_DIV   = 1024;
    localparam int KB_DB_SAMPLES = 4;

    function automatic int kb_idx(input int row, input int col, input int cols = KB_COLS);
        return col + row * cols;
    endfunction
endpackage

// File: rtl/kb_debounce_cell.sv
// One key: 2-FF synchroniser followed by a tick-driven debounce counter.
module kb_debounce_cell
    import kb_pkg::*;
#(
    parameter int DB_SAMPLES = KB_DB_SAMPLES
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic raw_i,
    output logic db_o,
    output logic toggle_o
);
    localparam int CW = $clog2(DB_SAMPLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_SAMPLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only advances on ticks; any agreeing tick restarts the run.
    always_comb begin
        cnt_d    = cnt_q;
        db_d     = db_q;
        toggle_o = 1'b0;
        if (tick_i) begin
            if (sync2_q != db_q) begin
                if (cnt_q == CNT_LAST) begin
                    db_d     = ~db_q;
                    cnt_d    = '0;
                    toggle_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    assign db_o = db_q;
endmodule

// File: rtl/kb_matrix_scan.sv
// Debounced keyboard matrix and tape input, presented as an active-low bus read value.
module kb_matrix_scan
    import kb_pkg::*;
#(
    parameter int ROWS       = KB_ROWS,
    parameter int COLS       = KB_COLS,
    parameter int DW         = KB_DW,
    parameter int TAPE_BIT   = KB_TAPE_BIT,
    parameter int TICK_DIV   = KB_TICK_DIV,
    parameter int DB_SAMPLES = KB_DB_SAMPLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS*COLS-1:0] keycaps,
    input  logic                 tape_in,
    input  logic [ROWS-1:0]      row_n,
    output logic [DW-1:0]        dout,
    output logic                 key_change,
    output logic                 any_key,
    output logic                 tape_edge
);
    localparam int NKEYS = ROWS * COLS;
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);

    logic [PW-1:0]    pre_q, pre_d;
    logic             tick;
    logic [NKEYS-1:0] db;
    logic [NKEYS-1:0] toggle;
    logic [COLS-1:0]  col_n;
    logic             tape_s1_q, tape_s2_q;
    logic             key_change_q, tape_edge_q;

    assign tick  = (pre_q == PRE_LAST);
    assign pre_d = tick ? '0 : pre_q + PRE_ONE;

    for (genvar k = 0; k < NKEYS; k++) begin : g_key
        kb_debounce_cell #(
            .DB_SAMPLES(DB_SAMPLES)
        ) u_cell (
            .clk     (clk),
            .reset   (reset),
            .tick_i  (tick),
            .raw_i   (keycaps[k]),
            .db_o    (db[k]),
            .toggle_o(toggle[k])
        );
    end

    // Every selected row contributes; aliasing across rows is deliberate.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [ROWS-1:0] hit;
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            assign hit[r] = ~row_n[r] & db[kb_idx(r, c, COLS)];
        end
        assign col_n[c] = ~|hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q        <= '0;
            tape_s1_q    <= 1'b1;
            tape_s2_q    <= 1'b1;
            key_change_q <= 1'b0;
            tape_edge_q  <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            tape_s1_q    <= tape_in;
            tape_s2_q    <= tape_s1_q;
            key_change_q <= |toggle;
            tape_edge_q  <= tape_s1_q ^ tape_s2_q;
        end
    end

    always_comb begin
        dout             = '1;
        dout[COLS-1:0]   = col_n;
        dout[TAPE_BIT]   = tape_s2_q;
    end

    assign any_key    = |db;
    assign key_change = key_change_q;
    assign tape_edge  = tape_edge_q;
endmodule
